// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - write-back line buffer between the dcache memory port and data memory
//
// Dirty-line evictions are acked after one cycle and queued, then drained to
// memory in FIFO order. Line-fill reads hit in the buffer are forwarded
// directly; misses go downstream with priority over draining.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active-low
//   c_enable_i    cache request, held until c_ack_o
//   c_write_i     1 = line write (eviction), 0 = line read (fill)
//   c_addr_i      line-aligned request address
//   c_data_i      write line data
//   c_data_o      read line data, valid with c_ack_o, held between acks
//   c_ack_o       one-cycle completion pulse to the cache
//   mem_enable_o  memory request, held until mem_ack_i
//   mem_write_o   memory request type
//   mem_addr_o    memory address
//   mem_data_o    memory write data
//   mem_data_i    memory read data, valid with mem_ack_i
//   mem_ack_i     one-cycle memory completion pulse
module line_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_enable_i,
    input  logic              c_write_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_data_i,
    output logic [DATA_W-1:0] c_data_o,
    output logic              c_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int LINE_LSB = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ
    } state_t;

    state_t             state_q;
    logic [DEPTH-1:0]   valid_q;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic               accept;
    logic               req_write;
    logic               req_read;
    logic [DEPTH-1:0]   match_vec;
    logic               hit_any;
    logic               read_miss;
    logic               drain_busy;
    logic               hit_live;
    logic [PTR_W-1:0]   live_idx;
    logic [PTR_W-1:0]   fwd_idx;
    logic               do_coalesce;
    logic               do_push;
    logic               do_fwd;
    logic               do_pop;
    logic               read_done;

    // The ack cycle blocks acceptance so a held request is not served twice.
    assign accept    = c_enable_i && !c_ack_o;
    assign req_write = accept && c_write_i;
    assign req_read  = accept && !c_write_i;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] &&
                (addr_q[i][ADDR_W-1:LINE_LSB] == c_addr_i[ADDR_W-1:LINE_LSB]);
        end
    end

    assign hit_any   = |match_vec;
    assign read_miss = req_read && !hit_any;

    // The head counts as draining already in the cycle IDLE selects it: its
    // data is being copied into mem_data_o now, so a coalesce into it would
    // be lost when it pops.
    assign drain_busy = (state_q == S_DRAIN) ||
                        ((state_q == S_IDLE) && !read_miss && (count_q != '0));

    // A non-draining copy is the newest one for its line.
    always_comb begin
        hit_live = 1'b0;
        live_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec[i] && !(drain_busy && (PTR_W'(i) == head_q))) begin
                hit_live = 1'b1;
                live_idx = PTR_W'(i);
            end
        end
    end

    // A hit with no live copy can only be the draining head.
    assign fwd_idx = hit_live ? live_idx : head_q;

    assign do_coalesce = req_write && hit_live;
    // Full test uses the registered count, so a same-cycle pop frees nothing.
    assign do_push     = req_write && !hit_live && (count_q < CNT_W'(DEPTH));
    assign do_fwd      = req_read && hit_any;
    assign do_pop      = (state_q == S_DRAIN) && mem_ack_i;
    assign read_done   = (state_q == S_READ) && mem_ack_i;

    // Line storage; contents are qualified by valid_q, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_q[tail_q] <= c_addr_i;
            data_q[tail_q] <= c_data_i;
        end else if (do_coalesce) begin
            data_q[live_idx] <= c_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            c_ack_o      <= 1'b0;
            c_data_o     <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            c_ack_o <= do_coalesce || do_push || do_fwd || read_done;

            if (do_fwd) begin
                c_data_o <= data_q[fwd_idx];
            end else if (read_done) begin
                c_data_o <= mem_data_i;
            end

            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end

            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (read_miss) begin
                        state_q      <= S_READ;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= 1'b0;
                        mem_addr_o   <= c_addr_i;
                    end else if (count_q != '0) begin
                        state_q      <= S_DRAIN;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= 1'b1;
                        mem_addr_o   <= addr_q[head_q];
                        mem_data_o   <= data_q[head_q];
                    end
                end
                S_DRAIN: begin
                    if (mem_ack_i) begin
                        state_q      <= S_IDLE;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                    end
                end
                S_READ: begin
                    if (mem_ack_i) begin
                        state_q      <= S_IDLE;
                        mem_enable_o <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_write_buffer.sv
// tb/tb_line_write_buffer.sv - directed self-checking bench for line_write_buffer
module tb_line_write_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;

    localparam logic [DATA_W-1:0] DA  = {8{32'hA0A0_0001}};
    localparam logic [DATA_W-1:0] DA2 = {8{32'hA2A2_0002}};
    localparam logic [DATA_W-1:0] DB  = {8{32'hB0B0_0003}};
    localparam logic [DATA_W-1:0] DC1 = {8{32'hC1C1_0004}};
    localparam logic [DATA_W-1:0] DC2 = {8{32'hC2C2_0005}};
    localparam logic [DATA_W-1:0] DD  = {8{32'hD0D0_0006}};
    localparam logic [DATA_W-1:0] DE  = {8{32'hE0E0_0007}};
    localparam logic [DATA_W-1:0] DF  = {8{32'hF0F0_0008}};
    localparam logic [DATA_W-1:0] DG  = {8{32'h6060_0009}};

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              c_enable_i;
    logic              c_write_i;
    logic [ADDR_W-1:0] c_addr_i;
    logic [DATA_W-1:0] c_data_i;
    logic [DATA_W-1:0] c_data_o;
    logic              c_ack_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    int tests_run    = 0;
    int tests_failed = 0;

    bit                mem_hold  = 1'b0;
    int                mem_delay = 3;
    int                wait_cnt  = 0;
    logic [DATA_W-1:0] mem_rdata = '0;
    bit                op_write [$];
    logic [ADDR_W-1:0] op_addr  [$];
    logic [DATA_W-1:0] op_data  [$];

    always #5 clk_i = ~clk_i;

    line_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .c_enable_i   (c_enable_i),
        .c_write_i    (c_write_i),
        .c_addr_i     (c_addr_i),
        .c_data_i     (c_data_i),
        .c_data_o     (c_data_o),
        .c_ack_o      (c_ack_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    // Memory model: acks mem_delay cycles into a request unless held.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i || mem_ack_i) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (mem_enable_o) begin
                wait_cnt++;
                if (!mem_hold && wait_cnt >= mem_delay) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_rdata;
                    op_write.push_back(mem_write_o);
                    op_addr.push_back(mem_addr_o);
                    op_data.push_back(mem_write_o ? mem_data_o : mem_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int max,
                          output int lat, output logic [DATA_W-1:0] rd);
        bit got;
        got        = 1'b0;
        lat        = 0;
        rd         = '0;
        c_enable_i = 1'b1;
        c_write_i  = wr;
        c_addr_i   = a;
        c_data_i   = d;
        while (!got && lat < max) begin
            @(negedge clk_i);
            lat++;
            if (c_ack_o) begin
                got = 1'b1;
                rd  = c_data_o;
            end
        end
        if (!got) lat = -1;
        c_enable_i = 1'b0;
    endtask

    task automatic wait_drained(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk_i);
            if (dut.count_q == 0 && !mem_enable_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        c_addr_i   = '0;
        c_data_i   = '0;
        tick(3);
        rst_i = 1'b1;
        tick(1);
        tests_run++;
        if (c_ack_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_c_ack: got %b expected 0", c_ack_o);
        end
        tests_run++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mem_ctrl: got en=%b wr=%b expected 0 0", mem_enable_o, mem_write_o);
        end
        tests_run++;
        if (c_data_o !== '0 || mem_addr_o !== '0 || mem_data_o !== '0) begin
            tests_failed++; $display("FAIL reset_data: got c_data=%h mem_addr=%h expected zeros", c_data_o, mem_addr_o);
        end
        tests_run++;
        if (dut.count_q != 0) begin
            tests_failed++; $display("FAIL reset_count: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_drain();
        int lat, cyc, bad, n0;
        logic [DATA_W-1:0] rd;
        bit ok;
        mem_hold = 1'b0; mem_delay = 10; n0 = op_write.size();
        do_req(1'b1, 32'h100, DA, 20, lat, rd);
        tests_run++;
        if (lat != 1) begin
            tests_failed++; $display("FAIL drain_write_ack_latency: got %0d expected 1", lat);
        end
        tick(1);
        tests_run++;
        if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_data_o !== DA) begin
            tests_failed++; $display("FAIL drain_request: got en=%b wr=%b addr=%h expected 1 1 100", mem_enable_o, mem_write_o, mem_addr_o);
        end
        cyc = 0; bad = 0;
        while (!mem_ack_i && cyc < 50) begin
            if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_data_o !== DA) bad++;
            tick(1);
            cyc++;
        end
        tests_run++;
        if (cyc >= 50 || bad != 0) begin
            tests_failed++; $display("FAIL drain_hold_stable: got %0d unstable cycles, waited %0d, expected 0 and ack", bad, cyc);
        end
        tick(1);
        tests_run++;
        if (mem_enable_o !== 1'b0 || dut.count_q != 0) begin
            tests_failed++; $display("FAIL drain_release: got en=%b count=%0d expected 0 0", mem_enable_o, dut.count_q);
        end
        wait_drained(20, ok);
        tests_run++;
        if (!ok || op_write.size() != n0 + 1 || op_addr[n0] !== 32'h100 || op_data[n0] !== DA || op_write[n0] !== 1'b1) begin
            tests_failed++; $display("FAIL drain_memory_write: got %0d ops expected 1 write to 100 with A", op_write.size() - n0);
        end
    endtask

    task automatic test_forward();
        int lat, n0;
        logic [DATA_W-1:0] rd;
        bit ok;
        mem_hold = 1'b1; mem_delay = 3; n0 = op_write.size();
        do_req(1'b1, 32'h200, DB, 20, lat, rd);
        tick(3);
        do_req(1'b0, 32'h200, '0, 20, lat, rd);
        tests_run++;
        if (lat != 1 || rd !== DB) begin
            tests_failed++; $display("FAIL forward_read: got lat=%0d data=%h expected 1 and B", lat, rd);
        end
        tests_run++;
        if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            tests_failed++; $display("FAIL forward_no_mem_read: got wr=%b addr=%h expected 1 200", mem_write_o, mem_addr_o);
        end
        mem_hold = 1'b0;
        wait_drained(50, ok);
        tests_run++;
        if (!ok || op_write.size() != n0 + 1 || op_write[n0] !== 1'b1 || op_data[n0] !== DB) begin
            tests_failed++; $display("FAIL forward_ops: got %0d ops expected exactly one write of B", op_write.size() - n0);
        end
    endtask

    task automatic test_coalesce();
        int lat, n0;
        logic [DATA_W-1:0] rd;
        bit ok;
        mem_hold = 1'b1; n0 = op_write.size();
        do_req(1'b1, 32'h100, DA2, 20, lat, rd);
        tick(1);
        do_req(1'b1, 32'h300, DC1, 20, lat, rd);
        tick(1);
        do_req(1'b1, 32'h300, DC2, 20, lat, rd);
        tests_run++;
        if (lat != 1 || dut.count_q != 2) begin
            tests_failed++; $display("FAIL coalesce_ack_count: got lat=%0d count=%0d expected 1 2", lat, dut.count_q);
        end
        mem_hold = 1'b0;
        wait_drained(60, ok);
        tests_run++;
        if (!ok || op_write.size() != n0 + 2 || op_addr[n0] !== 32'h100 || op_data[n0] !== DA2
            || op_addr[n0+1] !== 32'h300 || op_data[n0+1] !== DC2) begin
            tests_failed++; $display("FAIL coalesce_ops: got %0d ops expected 100/A2 then 300/C2", op_write.size() - n0);
        end
    endtask

    task automatic test_full_stall();
        int lat, n0, bad, ack_at, n;
        logic [DATA_W-1:0] rd;
        bit ok, got;
        mem_hold = 1'b1; n0 = op_write.size();
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 32'h1000 + 32'(i) * 32'h40, {8{32'hF000_0000 + 32'(i)}}, 20, lat, rd);
            tests_run++;
            if (lat != 1) begin
                tests_failed++; $display("FAIL full_write%0d_ack: got %0d expected 1", i, lat);
            end
            tick(1);
        end
        tests_run++;
        if (dut.count_q != DEPTH) begin
            tests_failed++; $display("FAIL full_count: got %0d expected %0d", dut.count_q, DEPTH);
        end
        c_enable_i = 1'b1; c_write_i = 1'b1;
        c_addr_i = 32'h1000 + 32'(DEPTH) * 32'h40;
        c_data_i = {8{32'hF000_0000 + 32'(DEPTH)}};
        bad = 0;
        repeat (6) begin
            tick(1);
            if (c_ack_o) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL full_stall_no_ack: got %0d acks expected 0", bad);
        end
        mem_hold = 1'b0;
        ack_at = -100; got = 1'b0; n = 0;
        while (!got && n < 50) begin
            tick(1);
            n++;
            if (mem_ack_i) ack_at = n;
            if (c_ack_o) got = 1'b1;
        end
        c_enable_i = 1'b0;
        tests_run++;
        if (!got || n - ack_at != 2) begin
            tests_failed++; $display("FAIL full_fifth_ack_timing: got %0d cycles after mem ack expected 2", n - ack_at);
        end
        wait_drained(100, ok);
        bad = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (n0 + i >= op_addr.size() || op_addr[n0+i] !== 32'h1000 + 32'(i) * 32'h40) bad++;
        end
        tests_run++;
        if (!ok || bad != 0 || op_write.size() != n0 + DEPTH + 1) begin
            tests_failed++; $display("FAIL full_drain_order: got %0d out-of-order, %0d ops expected 0 and %0d", bad, op_write.size() - n0, DEPTH + 1);
        end
    endtask

    task automatic test_read_miss();
        int lat, n0, bad, ack_at, n;
        logic [DATA_W-1:0] rd;
        bit ok, got;
        mem_hold = 1'b1; mem_delay = 3; n0 = op_write.size();
        do_req(1'b1, 32'h100, DE, 20, lat, rd);
        tick(1);
        do_req(1'b1, 32'h140, DF, 20, lat, rd);
        tick(1);
        mem_rdata = DD;
        c_enable_i = 1'b1; c_write_i = 1'b0; c_addr_i = 32'h400;
        bad = 0;
        repeat (4) begin
            tick(1);
            if (c_ack_o || mem_write_o !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL miss_waits_for_drain: got %0d early events expected 0", bad);
        end
        mem_hold = 1'b0;
        ack_at = -100; got = 1'b0; n = 0;
        while (!got && n < 60) begin
            tick(1);
            n++;
            if (mem_ack_i) ack_at = n;
            if (c_ack_o) got = 1'b1;
        end
        c_enable_i = 1'b0;
        tests_run++;
        if (!got || n - ack_at != 1 || c_data_o !== DD || mem_enable_o !== 1'b0) begin
            tests_failed++; $display("FAIL miss_return: got lat=%0d en=%b data=%h expected 1 0 D", n - ack_at, mem_enable_o, c_data_o);
        end
        wait_drained(60, ok);
        tests_run++;
        if (!ok || op_write.size() != n0 + 3 || op_addr[n0] !== 32'h100 || op_write[n0+1] !== 1'b0
            || op_addr[n0+1] !== 32'h400 || op_addr[n0+2] !== 32'h140 || op_data[n0+2] !== DF) begin
            tests_failed++; $display("FAIL miss_op_order: got %0d ops expected W100 R400 W140", op_write.size() - n0);
        end
        mem_rdata = DG;
        tick(1);
        c_enable_i = 1'b1; c_write_i = 1'b0; c_addr_i = 32'h500;
        tick(1);
        tests_run++;
        if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h500) begin
            tests_failed++; $display("FAIL miss_idle_issue: got en=%b wr=%b addr=%h expected 1 0 500", mem_enable_o, mem_write_o, mem_addr_o);
        end
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            tick(1);
            n++;
            if (c_ack_o) got = 1'b1;
        end
        c_enable_i = 1'b0;
        tests_run++;
        if (!got || c_data_o !== DG) begin
            tests_failed++; $display("FAIL miss_idle_data: got ack=%b data=%h expected 1 G", got, c_data_o);
        end
        tick(1);
        tests_run++;
        if (c_ack_o !== 1'b0 || c_data_o !== DG) begin
            tests_failed++; $display("FAIL ack_single_data_hold: got ack=%b data=%h expected 0 G", c_ack_o, c_data_o);
        end
    endtask

    task automatic test_reset_mid_drain();
        int lat, n0, bad;
        logic [DATA_W-1:0] rd;
        mem_hold = 1'b1;
        do_req(1'b1, 32'h600, DA, 20, lat, rd);
        tick(1);
        tests_run++;
        if (mem_enable_o !== 1'b1) begin
            tests_failed++; $display("FAIL rst_precondition_draining: got en=%b expected 1", mem_enable_o);
        end
        #2 rst_i = 1'b0;
        #1;
        tests_run++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0
            || c_ack_o !== 1'b0 || c_data_o !== '0 || dut.count_q != 0) begin
            tests_failed++; $display("FAIL rst_async_clear: got en=%b wr=%b addr=%h count=%0d expected all 0", mem_enable_o, mem_write_o, mem_addr_o, dut.count_q);
        end
        tick(1);
        rst_i = 1'b1;
        mem_hold = 1'b0;
        n0 = op_write.size();
        bad = 0;
        repeat (10) begin
            tick(1);
            if (mem_enable_o !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || op_write.size() != n0) begin
            tests_failed++; $display("FAIL rst_no_request_after: got %0d enabled cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_forward();
        test_coalesce();
        test_full_stall();
        test_read_miss();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
